// File: rtl/mure_pkg.sv
// Shared types and defaults for the MURE trace ingress path.
// uop_entry_s is the commit-port record consumed by the trace FSM.
package mure_pkg;

    localparam int NRET_DEFAULT       = 2;
    localparam int FIFO_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
    } uop_entry_s;

endpackage

// File: rtl/mure_lane_compactor.sv
// Packs valid commit lanes into consecutive write slots in lane order and
// splits them into accepted / dropped counts against the free-slot budget.
module mure_lane_compactor
    import mure_pkg::*;
#(
    parameter int  NRET  = NRET_DEFAULT,
    parameter int  PTR_W = 3,
    localparam int CNT_W = $clog2(NRET + 1)
) (
    input  uop_entry_s [NRET-1:0] lanes,
    input  logic [PTR_W:0]        free,
    output logic [NRET-1:0]       slot_we,
    output uop_entry_s [NRET-1:0] slot_data,
    output logic [CNT_W-1:0]      accepted,
    output logic [CNT_W-1:0]      dropped
);

    always_comb begin
        int rank;
        slot_we   = '0;
        slot_data = '0;
        accepted  = '0;
        dropped   = '0;
        rank      = 0;
        // rank is the lane's position among valid lanes, i.e. its slot offset.
        for (int l = 0; l < NRET; l++) begin
            if (lanes[l].valid) begin
                if (rank < int'(free)) begin
                    for (int s = 0; s < NRET; s++) begin
                        if (s == rank) begin
                            slot_we[s]   = 1'b1;
                            slot_data[s] = lanes[l];
                        end
                    end
                    accepted = accepted + CNT_W'(1);
                end else begin
                    dropped = dropped + CNT_W'(1);
                end
                rank = rank + 1;
            end
        end
    end

endmodule

// File: rtl/mure_uop_fifo.sv
// Circular ingress FIFO ahead of the trace FSM: multi-lane compacting push,
// unconditional head pop, and overflow flag / saturating drop counter.
module mure_uop_fifo
    import mure_pkg::*;
#(
    parameter int  NRET       = NRET_DEFAULT,
    parameter int  DEPTH      = FIFO_DEPTH_DEFAULT,
    parameter int  DROP_CNT_W = 16,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(NRET + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  uop_entry_s [NRET-1:0] uop_entry_i,
    input  logic                  flush_i,
    output uop_entry_s            uop_entry_o,
    output logic [PTR_W:0]        count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    uop_entry_s              storage [DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic                    pop;
    logic [PTR_W:0]          free;
    logic [NRET-1:0]         slot_we;
    uop_entry_s [NRET-1:0]   slot_data;
    logic [CNT_W-1:0]        accepted;
    logic [CNT_W-1:0]        dropped;
    logic [DROP_CNT_W:0]     drop_sum;

    // The FSM never stalls, so a non-empty FIFO always pops and frees its head slot.
    assign pop      = (count_o != '0);
    assign free     = (PTR_W+1)'(DEPTH) - count_o + (PTR_W+1)'(pop);
    assign drop_sum = {1'b0, drop_cnt_o} + (DROP_CNT_W+1)'(dropped);

    mure_lane_compactor #(
        .NRET  (NRET),
        .PTR_W (PTR_W)
    ) u_compactor (
        .lanes     (uop_entry_i),
        .free      (free),
        .slot_we   (slot_we),
        .slot_data (slot_data),
        .accepted  (accepted),
        .dropped   (dropped)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (flush_i) begin
            rd_ptr  <= wr_ptr;
            count_o <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(accepted);
            rd_ptr  <= rd_ptr + PTR_W'(pop);
            count_o <= count_o + (PTR_W+1)'(accepted) - (PTR_W+1)'(pop);
            if (dropped != '0) begin
                overflow_o <= 1'b1;
                drop_cnt_o <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            for (int s = 0; s < NRET; s++) begin
                if (slot_we[s]) begin
                    storage[wr_ptr + PTR_W'(s)] <= slot_data[s];
                end
            end
        end
    end

    // Fields are zeroed when empty so no stale record reaches the FSM.
    always_comb begin
        uop_entry_o = '0;
        if (pop) begin
            uop_entry_o       = storage[rd_ptr];
            uop_entry_o.valid = 1'b1;
        end
    end

    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == (PTR_W+1)'(DEPTH));

endmodule

// File: tb/tb_mure_uop_fifo.sv
// Directed bench for mure_uop_fifo (NRET=2, DEPTH=8) with a queue reference
// model and hand-computed checkpoints.
module tb_mure_uop_fifo;
    import mure_pkg::*;

    localparam int NRET  = 2;
    localparam int DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush = 1'b0;
    uop_entry_s [NRET-1:0] uop_in = '0;
    uop_entry_s            uop_out;
    logic [3:0]            count;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic [15:0]           drop_cnt;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    int          m_drop = 0;
    logic        m_ovf = 1'b0;

    always #5 clk = ~clk;

    mure_uop_fifo #(
        .NRET       (NRET),
        .DEPTH      (DEPTH),
        .DROP_CNT_W (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .uop_entry_i (uop_in),
        .flush_i     (flush),
        .uop_entry_o (uop_out),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full),
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_instr;
        chk({tag, ".count"}, 64'(count), 64'(exp_q.size()));
        chk({tag, ".empty"}, 64'(empty), 64'(exp_q.size() == 0));
        chk({tag, ".full"}, 64'(full), 64'(exp_q.size() == DEPTH));
        chk({tag, ".valid"}, 64'(uop_out.valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            exp_instr = exp_q[0][31:0] + 32'd1;
            chk({tag, ".head_pc"}, uop_out.pc, exp_q[0]);
            chk({tag, ".head_instr"}, 64'(uop_out.instr), 64'(exp_instr));
        end else begin
            chk({tag, ".idle_pc"}, uop_out.pc, 64'd0);
            chk({tag, ".idle_instr"}, 64'(uop_out.instr), 64'd0);
        end
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
    endtask

    // Drive one cycle of stimulus, advance the reference model at the edge,
    // then sample the DUT 1 time unit after the edge.
    task automatic cycle(input string tag, input logic r, input logic fl,
                         input logic v0, input logic [63:0] p0,
                         input logic v1, input logic [63:0] p1);
        int free;
        rst             = r;
        flush           = fl;
        uop_in[0].valid = v0;
        uop_in[0].pc    = p0;
        uop_in[0].instr = p0[31:0] + 32'd1;
        uop_in[1].valid = v1;
        uop_in[1].pc    = p1;
        uop_in[1].instr = p1[31:0] + 32'd1;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            m_drop = 0;
            m_ovf  = 1'b0;
        end else if (fl) begin
            exp_q.delete();
        end else begin
            free = DEPTH - exp_q.size() + ((exp_q.size() != 0) ? 1 : 0);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (v0) begin
                if (free > 0) begin exp_q.push_back(p0); free--; end
                else begin m_drop++; m_ovf = 1'b1; end
            end
            if (v1) begin
                if (free > 0) begin exp_q.push_back(p1); free--; end
                else begin m_drop++; m_ovf = 1'b1; end
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 1'b0, 1'b0, 64'hdead_0000, 1'b0, 64'hdead_0004);
    endtask

    initial begin
        logic [63:0] pc_next;
        logic [63:0] exp_next;
        int          pushed;
        int          seen;

        // Reset then idle
        cycle("reset1", 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        cycle("reset2", 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        chk("reset.valid", 64'(uop_out.valid), 64'd0);
        chk("reset.count", 64'(count), 64'd0);
        chk("reset.empty", 64'(empty), 64'd1);
        idle("idle");

        // Dual push into empty FIFO
        cycle("dual", 1'b0, 1'b0, 1'b1, 64'h8000_0000, 1'b1, 64'h8000_0004);
        chk("dual.pc0", uop_out.pc, 64'h8000_0000);
        chk("dual.count0", 64'(count), 64'd2);
        idle("dual_d1");
        chk("dual.pc1", uop_out.pc, 64'h8000_0004);
        chk("dual.count1", 64'(count), 64'd1);
        idle("dual_d2");
        chk("dual.count2", 64'(count), 64'd0);
        chk("dual.valid2", 64'(uop_out.valid), 64'd0);

        // Sparse lane then alternating patterns
        cycle("sparse", 1'b0, 1'b0, 1'b0, 64'hbad0, 1'b1, 64'h100);
        chk("sparse.pc", uop_out.pc, 64'h100);
        chk("sparse.count", 64'(count), 64'd1);
        pc_next = 64'h200;
        for (int i = 0; i < 20; i++) begin
            case (i % 4)
                0: cycle("alt", 1'b0, 1'b0, 1'b1, pc_next, 1'b1, pc_next + 64'd4);
                1: cycle("alt", 1'b0, 1'b0, 1'b1, pc_next, 1'b0, pc_next + 64'd4);
                2: cycle("alt", 1'b0, 1'b0, 1'b0, pc_next, 1'b1, pc_next + 64'd4);
                default: idle("alt");
            endcase
            pc_next = pc_next + 64'd8;
        end
        for (int i = 0; i < DEPTH; i++) idle("drain1");

        // Overflow: both lanes every cycle from empty
        pc_next = 64'h4000;
        for (int i = 0; i < 10; i++) begin
            cycle("ovf", 1'b0, 1'b0, 1'b1, pc_next, 1'b1, pc_next + 64'd4);
            pc_next = pc_next + 64'd8;
            if (i == 6) chk("ovf.full_at7", 64'(full), 64'd1);
            if (i == 6) chk("ovf.no_drop_yet", 64'(overflow), 64'd0);
        end
        chk("ovf.count", 64'(count), 64'd8);
        chk("ovf.flag", 64'(overflow), 64'd1);
        chk("ovf.drops", 64'(drop_cnt), 64'd3);
        for (int i = 0; i < DEPTH + 1; i++) idle("drain2");

        // Wrap-around stream of 3*DEPTH entries
        pc_next  = 64'h1000;
        exp_next = 64'h1000;
        pushed   = 0;
        seen     = 0;
        for (int i = 0; i < 60; i++) begin
            if (pushed < 3 * DEPTH && (i % 3) == 0) begin
                cycle("wrap", 1'b0, 1'b0, 1'b1, pc_next, 1'b1, pc_next + 64'd4);
                pc_next = pc_next + 64'd8;
                pushed  = pushed + 2;
            end else begin
                idle("wrap");
            end
            if (uop_out.valid) begin
                chk("wrap.seq", uop_out.pc, exp_next);
                exp_next = exp_next + 64'd4;
                seen++;
            end
        end
        chk("wrap.total", 64'(seen), 64'(3 * DEPTH));

        // Flush mid-operation
        for (int i = 0; i < 4; i++) begin
            cycle("fill", 1'b0, 1'b0, 1'b1, pc_next, 1'b1, pc_next + 64'd4);
            pc_next = pc_next + 64'd8;
        end
        chk("fill.count5", 64'(count), 64'd5);
        cycle("flush", 1'b0, 1'b1, 1'b1, 64'hf000, 1'b1, 64'hf004);
        chk("flush.count", 64'(count), 64'd0);
        chk("flush.valid", 64'(uop_out.valid), 64'd0);
        chk("flush.drops", 64'(drop_cnt), 64'd3);
        idle("post_flush");

        // Refill then reset
        cycle("refill", 1'b0, 1'b0, 1'b1, 64'h7000, 1'b1, 64'h7004);
        cycle("refill", 1'b0, 1'b0, 1'b1, 64'h7008, 1'b1, 64'h700c);
        chk("refill.count3", 64'(count), 64'd3);
        cycle("mid_reset", 1'b1, 1'b0, 1'b1, 64'h7010, 1'b1, 64'h7014);
        chk("mid_reset.ovf", 64'(overflow), 64'd0);
        chk("mid_reset.drops", 64'(drop_cnt), 64'd0);
        chk("mid_reset.count", 64'(count), 64'd0);
        idle("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
